// File: rtl/control_tx.sv
// control_tx: byte-serial command transmitter for the scanner control link.
// Accepts one register-write command at a time, frames it as
//   0xA5, addr, N value bytes (MSB first), XOR checksum (addr ^ value bytes),
// and presents each byte on data/data_rdy until the sink strobes data_clk.
// Every byte is followed by one idle cycle with data_rdy low.
//
// Ports:
//   clk_100M    system clock, rising edge
//   rst         synchronous active-high reset
//   cmd_valid   command present            cmd_ready  block can accept
//   cmd_addr    register address (8)       cmd_value  write value (24, right-aligned)
//   cmd_done    pulse: frame fully sent    cmd_err    pulse: bad address or timeout
//   err_timeout sticky timeout flag        busy       frame in progress
//   data        byte to sink               data_rdy   data valid
//   data_clk    sink consume strobe
module control_tx #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_addr,
  input  logic [23:0] cmd_value,
  output logic        cmd_done,
  output logic        cmd_err,
  output logic        err_timeout,
  output logic        busy,
  output logic [7:0]  data,
  output logic        data_rdy,
  input  logic        data_clk
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t            state;
  logic [7:0]        addr_q;
  logic [23:0]       value_q;
  logic [2:0]        idx;
  logic [CNT_W-1:0]  cnt;

  // Number of value bytes carried for an address; 0 marks an invalid address.
  function automatic logic [1:0] byte_count(input logic [7:0] a);
    case (a)
      8'h00, 8'h04, 8'h05: byte_count = 2'd1;
      8'h01, 8'h02:        byte_count = 2'd2;
      8'h03:               byte_count = 2'd3;
      default:             byte_count = 2'd0;
    endcase
  endfunction

  // Byte at position i of the frame for (a, v). Value bits above 8N are ignored.
  function automatic logic [7:0] frame_byte(input logic [2:0] i,
                                            input logic [7:0] a,
                                            input logic [23:0] v);
    int          n;
    logic [7:0]  chk;
    logic [23:0] sh;
    n   = int'(byte_count(a));
    chk = a ^ v[7:0];
    if (n >= 2) chk = chk ^ v[15:8];
    if (n >= 3) chk = chk ^ v[23:16];
    sh  = '0;
    if (i == 3'd0) begin
      frame_byte = HEADER;
    end else if (i == 3'd1) begin
      frame_byte = a;
    end else if (int'(i) < n + 2) begin
      // position 2 is the most significant of the N value bytes
      sh = v >> (8 * (n + 1 - int'(i)));
      frame_byte = sh[7:0];
    end else begin
      frame_byte = chk;
    end
  endfunction

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      cmd_done    <= 1'b0;
      cmd_err     <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
      data        <= 8'h00;
      data_rdy    <= 1'b0;
      idx         <= '0;
      cnt         <= '0;
    end else begin
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          data_rdy  <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            if (byte_count(cmd_addr) != 2'd0) begin
              addr_q      <= cmd_addr;
              value_q     <= cmd_value;
              err_timeout <= 1'b0;
              idx         <= '0;
              cnt         <= '0;
              data        <= HEADER;
              data_rdy    <= 1'b1;
              cmd_ready   <= 1'b0;
              busy        <= 1'b1;
              state       <= SEND;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        SEND: begin
          if (data_clk) begin
            data_rdy <= 1'b0;
            idx      <= idx + 3'd1;
            cnt      <= '0;
            state    <= GAP;
          end else if (cnt == CNT_LAST) begin
            // sink stalled too long: abandon the frame
            data_rdy    <= 1'b0;
            cmd_err     <= 1'b1;
            err_timeout <= 1'b1;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          cnt <= '0;
          if (int'(idx) < int'(byte_count(addr_q)) + 3) begin
            data     <= frame_byte(idx, addr_q, value_q);
            data_rdy <= 1'b1;
            state    <= SEND;
          end else begin
            cmd_done  <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_tx.sv
// Directed testbench for control_tx (TIMEOUT_CYCLES = 16).
module tb_control_tx;

  logic        clk_100M = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [23:0] cmd_value;
  logic        cmd_done;
  logic        cmd_err;
  logic        err_timeout;
  logic        busy;
  logic [7:0]  data;
  logic        data_rdy;
  logic        data_clk;

  always #5 clk_100M = ~clk_100M;

  control_tx #(.TIMEOUT_CYCLES(16)) dut (
    .clk_100M    (clk_100M),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_value   (cmd_value),
    .cmd_done    (cmd_done),
    .cmd_err     (cmd_err),
    .err_timeout (err_timeout),
    .busy        (busy),
    .data        (data),
    .data_rdy    (data_rdy),
    .data_clk    (data_clk)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_100M);
    #1;
  endtask

  // Present a command for exactly one accept edge.
  task automatic start_cmd(input logic [7:0] a, input logic [23:0] v);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin
      tick();
      w++;
    end
    check("ready_before_accept", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_value = v;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Act as the sink right after the accept edge. hold=1 keeps data_clk high;
  // hold=0 strobes one cycle after each data_rdy rise. exp_cyc is the number of
  // cycles from the accept edge to cmd_done. linger=0 returns on the cmd_done cycle.
  task automatic run_frame(input string tag, input bit hold, input int exp_cyc, input bit linger);
    int cyc, ndone, nerr, done_cyc;
    bit prev;
    cyc = 0; ndone = 0; nerr = 0; done_cyc = -1; prev = 1'b0;
    got_q.delete();
    check({tag, "_first_rdy"}, 32'(data_rdy), 32'd1);
    check({tag, "_err_timeout_clr"}, 32'(err_timeout), 32'd0);
    while (cyc < 80) begin
      if (cmd_done) begin
        ndone++;
        done_cyc = cyc;
        check({tag, "_ready_at_done"}, 32'(cmd_ready), 32'd1);
      end
      if (cmd_err) nerr++;
      if (data_rdy && !prev) got_q.push_back(data);
      if (done_cyc >= 0 && (!linger || cyc >= done_cyc + 3)) break;
      data_clk = hold ? 1'b1 : (data_rdy && prev);
      prev = data_rdy;
      tick();
      cyc++;
    end
    data_clk = 1'b0;
    check({tag, "_done_count"}, 32'(ndone), 32'd1);
    check({tag, "_err_count"}, 32'(nerr), 32'd0);
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
    check({tag, "_byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
  endtask

  initial begin
    int n, rises, bad;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_value = '0; data_clk = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_data", 32'(data), 32'h00);
    check("rst_data_rdy", 32'(data_rdy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_err", {30'd0, cmd_done, cmd_err}, 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // addr 0x01 value 0x00BEEF, delayed strobe: 5 bytes x 3 cycles
    exp_q = '{8'hA5, 8'h01, 8'hBE, 8'hEF, 8'h50};
    start_cmd(8'h01, 24'h00BEEF);
    check("busy_in_frame", 32'(busy), 32'd1);
    check("ready_in_frame", 32'(cmd_ready), 32'd0);
    run_frame("gain", 1'b0, 15, 1'b1);

    // addr 0x03 value 0x123456, data_clk held: 6 bytes in 12 cycles
    exp_q = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h73};
    start_cmd(8'h03, 24'h123456);
    run_frame("lines", 1'b1, 12, 1'b1);

    // invalid address
    start_cmd(8'h07, 24'h000001);
    check("inv_err_pulse", 32'(cmd_err), 32'd1);
    check("inv_data_rdy", 32'(data_rdy), 32'd0);
    check("inv_ready", 32'(cmd_ready), 32'd1);
    rises = 0; bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (data_rdy) rises++;
      if (cmd_err) bad++;
      if (!cmd_ready) bad++;
    end
    check("inv_no_rdy", 32'(rises), 32'd0);
    check("inv_single_err_ready", 32'(bad), 32'd0);

    // timeout on the addr byte
    start_cmd(8'h00, 24'h00005A);
    check("to_header", 32'(data), 32'hA5);
    data_clk = 1'b1;
    tick();
    data_clk = 1'b0;
    check("to_gap", 32'(data_rdy), 32'd0);
    tick();
    check("to_addr_byte", {23'd0, data_rdy, data}, {23'd0, 1'b1, 8'h00});
    n = 0;
    while (data_rdy && n < 40) begin
      tick();
      n++;
    end
    check("to_cycles", 32'(n), 32'd16);
    check("to_err_pulse", 32'(cmd_err), 32'd1);
    check("to_sticky", 32'(err_timeout), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    tick();
    check("to_err_one_cycle", 32'(cmd_err), 32'd0);
    check("to_sticky_held", 32'(err_timeout), 32'd1);
    exp_q = '{8'hA5, 8'h04, 8'h09, 8'h0D};
    start_cmd(8'h04, 24'h000009);
    run_frame("after_to", 1'b1, 8, 1'b1);

    // reset while the third byte of an addr 0x02 frame is presented
    start_cmd(8'h02, 24'h00ABCD);
    data_clk = 1'b1;
    n = 0;
    while (!(data_rdy && data == 8'hAB) && n < 20) begin
      tick();
      n++;
    end
    check("rst_mid_reached", {23'd0, data_rdy, data}, {23'd0, 1'b1, 8'hAB});
    rst = 1'b1;
    data_clk = 1'b0;
    tick();
    check("rst_mid_data_rdy", 32'(data_rdy), 32'd0);
    check("rst_mid_data", 32'(data), 32'h00);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done_err", {30'd0, cmd_done, cmd_err}, 32'd0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cmd_done || cmd_err || data_rdy) bad++;
    end
    check("rst_mid_quiet", 32'(bad), 32'd0);
    exp_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h24};
    start_cmd(8'h02, 24'hFF1234);
    run_frame("after_rst", 1'b1, 10, 1'b1);

    // back-to-back: second command accepted on the cmd_done cycle
    exp_q = '{8'hA5, 8'h04, 8'h09, 8'h0D};
    start_cmd(8'h04, 24'h000009);
    run_frame("b2b_a", 1'b1, 8, 1'b0);
    check("b2b_done_now", 32'(cmd_done), 32'd1);
    exp_q = '{8'hA5, 8'h05, 8'h80, 8'h85};
    start_cmd(8'h05, 24'h000080);
    run_frame("b2b_b", 1'b1, 8, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
